rv64_divider: RTL and testbench

Iterative radix-2 integer divider for the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW instructions. It sits beside the execute stage: the execute stage launches an operation with a valid/ready handshake, and the memory stage stalls on `in_ready` low and captures `result` when `out_valid` pulses. Raising reset aborts an in-flight operation, which the pipeline does on memory-access traps.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_sign_fix.sv | 29 ++
 rtl/rv64_divider.sv | 144 ++++++++++++++
 tb/tb_rv64_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the RV64M iterative divider.
//   - op encodings carried on ALUctr_in
//   - FSM state encoding
//   - full (64) and word (32) operand widths
package div_pkg;

  localparam int XLEN = 64;
  localparam int WLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign helper shared by operand preparation and result
// correction.
//   val  : input value (64 bits)
//   is_w : word mode, only bits [31:0] of the negated value are kept
//   neg  : negate val (two's complement) before width handling
//   sext : in word mode, sign-extend bit 31 (1) or zero-extend (0)
//   res  : processed value (64 bits)
// Operand preparation uses sext=0 so that |-2^31| = 2^31 stays positive in
// the 64-bit datapath; result correction uses sext=1.
module div_sign_fix import div_pkg::*; (
  input  logic [XLEN-1:0] val,
  input  logic            is_w,
  input  logic            neg,
  input  logic            sext,
  output logic [XLEN-1:0] res
);

  logic [XLEN-1:0] t;

  always_comb begin
    t = neg ? (~val + 64'd1) : val;
    if (is_w) begin
      res = sext ? {{WLEN{t[WLEN-1]}}, t[WLEN-1:0]} : {{WLEN{1'b0}}, t[WLEN-1:0]};
    end else begin
      res = t;
    end
  end

endmodule

// File: rtl/rv64_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and the W forms.
//   clk, rst      : clock, synchronous active-low reset
//   src1_in       : dividend
//   src2_in       : divisor
//   is_w          : word operation (32-bit operands, sign-extended result)
//   ALUctr_in     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   in_valid      : request strobe
//   in_ready      : accepting requests (idle or completion cycle)
//   out_valid     : one-cycle pulse, result is new
//   result        : quotient or remainder, held until the next completion
//
// Handshake: a request transfers on a rising edge where in_valid and
// in_ready are both high; in_valid while in_ready is low is ignored and
// need not be held. out_valid has no back-pressure: the consumer must take
// result in the cycle out_valid is high (it stays readable afterwards).
//
// Divide-by-zero and signed overflow complete in the cycle after accept.
// Other ops iterate N times (64, or 32 for W); the N-th iteration edge
// also registers the corrected result and enters DONE.
module rv64_divider import div_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] src1_in,
  input  logic [XLEN-1:0] src2_in,
  input  logic            is_w,
  input  logic [1:0]      ALUctr_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  div_state_t         state;
  logic [2*XLEN-1:0]  rq;         // {partial remainder, dividend/quotient}
  logic [XLEN-1:0]    divisor_q;
  logic [5:0]         cnt;        // iterations remaining minus one
  logic               w_q;
  logic               rem_q;
  logic               neg_q;
  logic [XLEN-1:0]    result_q;

  // Request decode.
  logic            op_signed, op_rem, s1_neg, s2_neg;
  logic            div_zero, ovf, fast, accept, busy;
  logic [XLEN-1:0] abs1, abs2, fast_val;

  assign op_signed = ~ALUctr_in[0];
  assign op_rem    = ALUctr_in[1];
  assign s1_neg    = op_signed & (is_w ? src1_in[WLEN-1] : src1_in[XLEN-1]);
  assign s2_neg    = op_signed & (is_w ? src2_in[WLEN-1] : src2_in[XLEN-1]);

  assign div_zero = is_w ? (src2_in[WLEN-1:0] == '0) : (src2_in == '0);
  assign ovf = op_signed & (is_w ?
      ((src1_in[WLEN-1:0] == 32'h8000_0000) && (src2_in[WLEN-1:0] == 32'hFFFF_FFFF)) :
      ((src1_in == 64'h8000_0000_0000_0000) && (src2_in == {XLEN{1'b1}})));
  assign fast = div_zero | ovf;

  // Raw fast-path value; width handling is done by the output sign fixer.
  always_comb begin
    if (op_rem) fast_val = div_zero ? src1_in : '0;
    else        fast_val = div_zero ? {XLEN{1'b1}} : src1_in;
  end

  assign in_ready  = (state != ST_BUSY);
  assign out_valid = (state == ST_DONE);
  assign result    = result_q;
  assign accept    = in_valid & in_ready;
  assign busy      = (state == ST_BUSY);

  div_sign_fix u_abs1 (.val(src1_in), .is_w(is_w), .neg(s1_neg), .sext(1'b0), .res(abs1));
  div_sign_fix u_abs2 (.val(src2_in), .is_w(is_w), .neg(s2_neg), .sext(1'b0), .res(abs2));

  // One restoring step. The shifted partial remainder can reach 65 bits.
  logic [XLEN:0]     trial;
  logic              ge;
  logic [XLEN-1:0]   diff;
  logic [2*XLEN-1:0] rq_next;
  logic [XLEN-1:0]   final_val;

  always_comb begin
    trial     = rq[2*XLEN-1:XLEN-1];
    ge        = (trial >= {1'b0, divisor_q});
    // When ge holds the difference fits in 64 bits, so mod-2^64 is exact.
    diff      = trial[XLEN-1:0] - divisor_q;
    rq_next   = {(ge ? diff : trial[XLEN-1:0]), rq[XLEN-2:0], ge};
    final_val = rem_q ? rq_next[2*XLEN-1:XLEN] : rq_next[XLEN-1:0];
  end

  // Output correction: iterative result while busy, fast path otherwise.
  logic [XLEN-1:0] post_val, post_res;
  logic            post_w, post_neg;

  assign post_val = busy ? final_val : fast_val;
  assign post_w   = busy ? w_q : is_w;
  assign post_neg = busy & neg_q;

  div_sign_fix u_post (.val(post_val), .is_w(post_w), .neg(post_neg), .sext(1'b1), .res(post_res));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rq        <= '0;
      divisor_q <= '0;
      cnt       <= '0;
      w_q       <= 1'b0;
      rem_q     <= 1'b0;
      neg_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (fast) begin
              state    <= ST_DONE;
              result_q <= post_res;
            end else begin
              state <= ST_BUSY;
              // Word dividends start in the top half of the quotient field
              // so 32 shifts bring them fully into the remainder.
              rq        <= {{XLEN{1'b0}}, (is_w ? {abs1[WLEN-1:0], {WLEN{1'b0}}} : abs1)};
              divisor_q <= abs2;
              cnt       <= is_w ? 6'd31 : 6'd63;
              w_q       <= is_w;
              rem_q     <= op_rem;
              neg_q     <= op_rem ? s1_neg : (s1_neg ^ s2_neg);
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          rq  <= rq_next;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            state    <= ST_DONE;
            result_q <= post_res;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv64_divider.sv
// Directed self-checking bench for rv64_divider. Stimulus pushes the
// expected result and completion cycle; a negedge monitor pops and compares
// whenever out_valid is seen.
module tb_rv64_divider;
  import div_pkg::*;

  logic            clk;
  logic            rst;
  logic [63:0]     src1_in;
  logic [63:0]     src2_in;
  logic            is_w;
  logic [1:0]      ALUctr_in;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic [63:0]     result;

  logic [63:0] exp_q[$];
  int          cyc_q[$];
  int          cyc;
  int          n_pass;
  int          n_total;

  rv64_divider dut (
    .clk(clk), .rst(rst), .src1_in(src1_in), .src2_in(src2_in),
    .is_w(is_w), .ALUctr_in(ALUctr_in), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .result(result)
  );

  // Clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        chk("result", result, e);
        chk("latency", 64'(cyc), 64'(ec));
      end
    end
  end

  // Driver: called just after a negedge; returns just after the next negedge.
  task automatic drive(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input bit push);
    chk("ready_at_issue", 64'(in_ready), 64'd1);
    src1_in   = a;
    src2_in   = b;
    is_w      = w;
    ALUctr_in = op;
    in_valid  = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + 1 + lat);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ready_after_accept", 64'(in_ready), (lat == 0) ? 64'd1 : 64'd0);
    @(negedge clk);
  endtask

  // Leaves the caller at the negedge where out_valid is high.
  task automatic wait_done();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("timeout", 64'd1, 64'd0);
  endtask

  task automatic run(input logic [1:0] op, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int lat);
    drive(op, w, a, b, exp, lat, 1'b1);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b0;
    src1_in   = '0;
    src2_in   = '0;
    is_w      = 1'b0;
    ALUctr_in = 2'b00;
    in_valid  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", result, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // 64-bit signed
    run(DIV_OP_DIV,  1'b0, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 64);
    run(DIV_OP_REM,  1'b0, 64'd100, -64'sd7, 64'd2, 64);
    run(DIV_OP_REMU, 1'b0, 64'd1000, 64'd7, 64'd6, 64);
    // Word ops
    run(DIV_OP_DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 32);
    run(DIV_OP_REM,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    run(DIV_OP_DIV,  1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 32);
    run(DIV_OP_DIV,  1'b1, 64'h1234_5678_0000_0064, 64'hABCD_0000_FFFF_FFF9,
        64'hFFFF_FFFF_FFFF_FFF2, 32);
    // Divide by zero
    run(DIV_OP_DIVU, 1'b0, 64'h5555, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run(DIV_OP_REM,  1'b0, 64'h1234, 64'd0, 64'h1234, 0);
    run(DIV_OP_DIVU, 1'b1, 64'h7, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run(DIV_OP_REMU, 1'b1, 64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 0);
    // Signed overflow
    run(DIV_OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 0);
    run(DIV_OP_REM,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);

    // Back-to-back, with a request while busy that must be ignored
    drive(DIV_OP_DIVU, 1'b0, 64'd1000, 64'd10, 64'd100, 64, 1'b1);
    repeat (5) @(negedge clk);
    src1_in   = 64'd77;
    src2_in   = 64'd0;
    ALUctr_in = DIV_OP_DIVU;
    in_valid  = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    drive(DIV_OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1'b1);
    repeat (10) @(negedge clk);
    chk("result_held", result, 64'd100);
    wait_done();
    @(negedge clk);

    // Reset at iteration 10 aborts the op silently
    drive(DIV_OP_DIV, 1'b0, 64'd12345, 64'd5, 64'd0, 64, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", result, 64'd0);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    chk("abort_no_output", result, 64'd0);
    run(DIV_OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 64);
    repeat (5) @(negedge clk);
    chk("final_result_held", result, 64'd3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
